// File: rtl/weight_pkg.sv
// Constants and FSM state encoding shared by the weight fetch controller and the weight RAM.
package weight_pkg;

  localparam int N     = 10;
  localparam int AW    = 7;
  localparam int WW    = 10;
  localparam int DEPTH = 65;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    CAPT,
    STREAM,
    FIN
  } state_e;

endpackage

// File: rtl/weight_shift_buf.sv
// Holds one RAM vector of N weights; parallel load, then shifts one word toward
// word 0 on every accepted transfer so word 0 is always the word on offer.
module weight_shift_buf #(
  parameter int N  = weight_pkg::N,
  parameter int WW = weight_pkg::WW
) (
  input  logic            Clock,
  input  logic            Rst,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [N*WW-1:0] data_i,
  output logic [WW-1:0]   word_o
);

  logic [N*WW-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (load_i)       buf_d = data_i;
    else if (shift_i) buf_d = buf_q >> WW;
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) buf_q <= '0;
    else      buf_q <= buf_d;
  end

  assign word_o = buf_q[WW-1:0];

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Fetches NumVec vectors of N weights from the weight RAM and streams them
// one word at a time over a valid/ready interface.
//
// state  | meaning
// IDLE   | waiting for Start
// CHECK  | range check of Base/NumVec against RAM depth
// ISSUE  | address on RAM_Addr, waits out Init_busy
// CAPT   | RAM read data arriving, loaded into buffer at the end
// STREAM | offering buffered words downstream
// FIN    | Done (and Err) pulse
module weight_fetch_ctrl #(
  parameter int N     = weight_pkg::N,
  parameter int AW    = weight_pkg::AW,
  parameter int WW    = weight_pkg::WW,
  parameter int DEPTH = weight_pkg::DEPTH
) (
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [AW-1:0]        Base,
  input  logic [2:0]           NumVec,
  input  logic                 Init_busy,
  input  logic [N*WW-1:0]      RAM_Q,
  output logic [AW-1:0]        RAM_Addr,
  output logic                 RAM_WE,
  output logic signed [WW-1:0] W_data,
  output logic                 W_valid,
  input  logic                 W_ready,
  output logic                 W_last,
  output logic                 W_end,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err
);

  import weight_pkg::*;

  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);

  state_e        state_q;
  logic [AW-1:0] base_q, addr_q;
  logic [2:0]    numvec_q, k_q;
  logic [JW-1:0] j_q;
  logic          valid_q, last_q, end_q, busy_q, done_q, err_q;
  logic [8:0]    span_last;
  logic          xfer, k_final;
  logic [WW-1:0] buf_word;

  // Address of the last word the job would touch.
  assign span_last = 9'(base_q) + 9'(numvec_q) * 9'(N) - 9'd1;
  assign xfer      = valid_q & W_ready;
  assign k_final   = (k_q == numvec_q - 3'd1);

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      numvec_q <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      j_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (Start) begin
          base_q   <= Base;
          numvec_q <= NumVec;
          k_q      <= '0;
          j_q      <= '0;
          busy_q   <= 1'b1;
          state_q  <= CHECK;
        end
        CHECK: begin
          if (numvec_q == 3'd0) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (span_last > 9'(DEPTH - 1)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= FIN;
          end else begin
            addr_q  <= base_q;
            state_q <= ISSUE;
          end
        end
        ISSUE: if (!Init_busy) state_q <= CAPT;
        CAPT: begin
          j_q     <= '0;
          valid_q <= 1'b1;
          last_q  <= (J_LAST == '0);
          end_q   <= (J_LAST == '0) && k_final;
          state_q <= STREAM;
        end
        STREAM: if (xfer) begin
          if (!last_q) begin
            j_q    <= j_q + 1'b1;
            last_q <= (j_q + 1'b1 == J_LAST);
            end_q  <= (j_q + 1'b1 == J_LAST) && k_final;
          end else if (!end_q) begin
            k_q     <= k_q + 3'd1;
            addr_q  <= addr_q + AW'(N);
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= ISSUE;
          end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  weight_shift_buf #(.N(N), .WW(WW)) u_buf (
    .Clock   (Clock),
    .Rst     (Rst),
    .load_i  (state_q == CAPT),
    .shift_i (xfer),
    .data_i  (RAM_Q),
    .word_o  (buf_word)
  );

  assign RAM_Addr = addr_q;
  assign RAM_WE   = 1'b0;
  assign W_data   = buf_word;
  assign W_valid  = valid_q;
  assign W_last   = last_q;
  assign W_end    = end_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: RAM model with word[a]=a, scoreboard of
// expected stream words, timing and handshake checks.
module tb_weight_fetch_ctrl;

  localparam int N     = 10;
  localparam int AW    = 7;
  localparam int WW    = 10;
  localparam int DEPTH = 65;

  logic                 Clock;
  logic                 Rst;
  logic                 Start;
  logic [AW-1:0]        Base;
  logic [2:0]           NumVec;
  logic                 Init_busy;
  logic [N*WW-1:0]      RAM_Q;
  logic [AW-1:0]        RAM_Addr;
  logic                 RAM_WE;
  logic signed [WW-1:0] W_data;
  logic                 W_valid;
  logic                 W_ready;
  logic                 W_last;
  logic                 W_end;
  logic                 Busy;
  logic                 Done;
  logic                 Err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [WW+1:0] sb[$];
  logic [WW+1:0] held, exp_w;
  int  done_n, err_n, done_cyc, first_valid_cyc, last_xfer_cyc, xfer_n, gap_n, start_cyc;
  bit  first_seen, err_at_done, gap_chk, stall_prev;

  weight_fetch_ctrl #(.N(N), .AW(AW), .WW(WW), .DEPTH(DEPTH)) dut (
    .Clock     (Clock),
    .Rst       (Rst),
    .Start     (Start),
    .Base      (Base),
    .NumVec    (NumVec),
    .Init_busy (Init_busy),
    .RAM_Q     (RAM_Q),
    .RAM_Addr  (RAM_Addr),
    .RAM_WE    (RAM_WE),
    .W_data    (W_data),
    .W_valid   (W_valid),
    .W_ready   (W_ready),
    .W_last    (W_last),
    .W_end     (W_end),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Weight RAM: one-cycle read latency, reads ignored (garbage) during init.
  always @(posedge Clock) begin
    for (int i = 0; i < N; i++) begin
      if (Init_busy) RAM_Q[i*WW +: WW] <= '1;
      else RAM_Q[i*WW +: WW] <= (int'(RAM_Addr) + i < DEPTH) ? WW'(int'(RAM_Addr) + i) : '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (!Rst) begin
      stall_prev = 1'b0;
      gap_chk    = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", {W_valid, W_end, W_last, W_data}, {1'b1, held});
      if (W_valid) begin
        if (!first_seen) begin
          first_seen      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (gap_chk) begin
          check("vec_gap", gap_n, 2);
          gap_chk = 1'b0;
        end
      end else begin
        gap_n++;
      end
      if (W_valid && W_ready) begin
        xfer_n++;
        last_xfer_cyc = cyc;
        check("word_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_w = sb.pop_front();
          check("xfer", {W_end, W_last, W_data}, exp_w);
        end
        if (W_last && !W_end) begin
          gap_chk = 1'b1;
          gap_n   = 0;
        end
      end
      stall_prev = W_valid && !W_ready;
      held       = {W_end, W_last, W_data};
      if (Done) begin
        done_n++;
        done_cyc    = cyc;
        err_at_done = Err;
      end
      if (Err) err_n++;
    end
  end

  task automatic push_exp(input int base, input int nv);
    logic [WW+1:0] w;
    for (int v = 0; v < nv; v++)
      for (int j = 0; j < N; j++) begin
        w[WW-1:0] = WW'(base + v * N + j);
        w[WW]     = (j == N - 1);
        w[WW+1]   = (j == N - 1) && (v == nv - 1);
        sb.push_back(w);
      end
  endtask

  task automatic launch(input int base, input int nv, input bit ib);
    @(posedge Clock); #1;
    Base      = AW'(base);
    NumVec    = 3'(nv);
    Start     = 1'b1;
    Init_busy = ib;
    @(posedge Clock); #1;
    start_cyc = cyc;
    Start     = 1'b0;
  endtask

  task automatic job(input int base, input int nv, input bit exp_err, input bit rnd, input int busy_cyc);
    int  n;
    bit  stream;
    stream      = !exp_err && nv > 0;
    done_n      = 0;
    err_n       = 0;
    xfer_n      = 0;
    first_seen  = 1'b0;
    err_at_done = 1'b0;
    if (stream) push_exp(base, nv);
    launch(base, nv, busy_cyc > 0);
    check("busy_hi", Busy, 1);
    n = 0;
    while (done_n == 0 && n < 400) begin
      @(posedge Clock); #1;
      n++;
      Init_busy = (n + 1 < busy_cyc);
      if (busy_cyc > 0 && n < busy_cyc) check("issue_addr", RAM_Addr, base);
      if (rnd) begin
        W_ready = 1'($urandom_range(0, 1));
        Start   = ($urandom_range(0, 7) == 0);
        Base    = AW'($urandom);
        NumVec  = 3'($urandom);
      end
    end
    Start     = 1'b0;
    W_ready   = 1'b1;
    Init_busy = 1'b0;
    @(posedge Clock); #1;
    check("done_once", done_n, 1);
    check("err_count", err_n, exp_err);
    check("err_with_done", err_at_done, exp_err);
    check("busy_lo", Busy, 0);
    check("ram_we", RAM_WE, 0);
    check("sb_empty", sb.size(), 0);
    if (stream) begin
      check("first_valid_lat", first_valid_cyc - start_cyc, 3 + ((busy_cyc > 2) ? busy_cyc - 2 : 0));
      check("done_after_last", done_cyc - last_xfer_cyc, 1);
      check("xfer_total", xfer_n, nv * N);
    end else begin
      check("no_valid", first_seen, 0);
      check("done_lat", done_cyc - start_cyc, 1);
    end
  endtask

  initial begin
    int n;
    Rst       = 1'b0;
    Start     = 1'b0;
    Base      = '0;
    NumVec    = '0;
    Init_busy = 1'b0;
    W_ready   = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_addr", RAM_Addr, 0);
    check("rst_data", W_data, 0);
    check("rst_valid", W_valid, 0);
    check("rst_last", W_last, 0);
    check("rst_end", W_end, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", Err, 0);
    check("rst_we", RAM_WE, 0);
    Rst = 1'b1;

    job(0, 2, 1'b0, 1'b0, 0);
    job(55, 1, 1'b0, 1'b0, 0);
    job(56, 1, 1'b1, 1'b0, 0);
    job(5, 0, 1'b0, 1'b0, 0);
    job(0, 7, 1'b1, 1'b0, 0);
    job(20, 3, 1'b0, 1'b0, 5);
    job(30, 3, 1'b0, 1'b1, 0);
    job(4, 6, 1'b0, 1'b1, 0);

    // Reset while the second vector is streaming.
    done_n = 0;
    xfer_n = 0;
    push_exp(0, 3);
    launch(0, 3, 1'b0);
    n = 0;
    while (xfer_n < 13 && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    check("reached_vec1", xfer_n, 13);
    #2;
    Rst = 1'b0;
    #1;
    check("mid_rst_outs", {W_valid, W_last, W_end, Busy, Done, Err, RAM_WE}, 0);
    check("mid_rst_data", W_data, 0);
    check("mid_rst_addr", RAM_Addr, 0);
    repeat (2) @(posedge Clock);
    #1;
    sb.delete();
    Rst = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("no_done_after_rst", done_n, 0);
    job(10, 2, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
